// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, types and the access-legality rule for the MEM stage.
`default_nettype none

package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } mem_state_t;

  // Lane 0 is the least significant byte.
  typedef logic [3:0][7:0] byte_lanes_t;

  // Stores only know sb/sh/sw; unsigned variants are load-only.
  function automatic logic access_legal(input logic is_load, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    case (f3)
      F3_LB:   ok = 1'b1;
      F3_LH:   ok = ~off[0];
      F3_LW:   ok = (off == 2'b00);
      F3_LBU:  ok = is_load;
      F3_LHU:  ok = is_load & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
// load_align: picks the addressed byte/half from a read word and sign/zero-extends it.
`default_nettype none

module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output byte_lanes_t lanes
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ext;

  always_comb begin
    case (offset)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    sel_half = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_LB:   ext = {{24{sel_byte[7]}}, sel_byte};
      F3_LH:   ext = {{16{sel_half[15]}}, sel_half};
      F3_LW:   ext = rdata;
      F3_LBU:  ext = {24'd0, sel_byte};
      F3_LHU:  ext = {16'd0, sel_half};
      default: ext = 32'd0;
    endcase

    lanes = ext;
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage (data-memory handshake, store lanes, load alignment) and MEM/WB register.
`default_nettype none

module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_alu_out,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [REG_AW-1:0] ex_destReg,
  input  logic              ex_regWrite,
  input  logic              ex_memtoreg,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [REG_AW-1:0] wb_destReg,
  output byte_lanes_t       wb_data_from_mem,
  output logic              wb_regWrite,
  output logic              wb_memtoreg,
  output logic [XLEN-1:0]   wb_alu_out,
  output logic              misalign_err
);

  mem_state_t  state, state_next;
  logic        is_mem, legal, access_err;
  logic        commit, commit_load;
  byte_lanes_t aligned;

  assign is_mem     = ex_valid & (ex_mem_read | ex_mem_write);
  assign legal      = access_legal(ex_mem_read, ex_funct3, ex_alu_out[1:0]);
  assign access_err = (state == IDLE) & is_mem & ~legal;

  assign dmem_we   = ex_mem_write;
  assign dmem_addr = {ex_alu_out[XLEN-1:2], 2'b00};

  always_comb begin
    case (ex_funct3[1:0])
      SIZE_B: begin
        dmem_be    = 4'b0001 << ex_alu_out[1:0];
        dmem_wdata = {4{ex_store_data[7:0]}};
      end
      SIZE_H: begin
        dmem_be    = 4'b0011 << ex_alu_out[1:0];
        dmem_wdata = {2{ex_store_data[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = ex_store_data;
      end
    endcase
  end

  // Upstream holds ex_* while stalled, so the response is aligned against the live inputs.
  load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (ex_alu_out[1:0]),
    .funct3 (ex_funct3),
    .lanes  (aligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    dmem_req    = 1'b0;
    mem_stall   = 1'b0;
    commit      = 1'b0;
    commit_load = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem && legal) begin
          dmem_req = 1'b1;
          if (ex_mem_write) begin
            commit    = dmem_ready;
            mem_stall = ~dmem_ready;
          end else begin
            mem_stall = 1'b1;
            if (dmem_ready) state_next = WAIT_RESP;
          end
        end else if (!is_mem) begin
          commit = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (dmem_rvalid) begin
          commit      = 1'b1;
          commit_load = 1'b1;
          state_next  = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Anything not committing this cycle (stall or faulting access) enters WB as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_destReg       <= '0;
      wb_data_from_mem <= '0;
      wb_regWrite      <= 1'b0;
      wb_memtoreg      <= 1'b0;
      wb_alu_out       <= '0;
      misalign_err     <= 1'b0;
    end else begin
      wb_destReg       <= ex_destReg;
      wb_alu_out       <= ex_alu_out;
      wb_regWrite      <= commit & ex_valid & ex_regWrite;
      wb_memtoreg      <= commit & ex_memtoreg;
      wb_data_from_mem <= commit_load ? aligned : '0;
      misalign_err     <= access_err;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed plus randomized transactions checked against a transaction-level model.
`default_nettype none

module tb_mem_wb_stage;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid, ex_mem_read, ex_mem_write, ex_regWrite, ex_memtoreg;
  logic [31:0]       ex_alu_out, ex_store_data;
  logic [2:0]        ex_funct3;
  logic [4:0]        ex_destReg;
  logic              mem_stall, dmem_req, dmem_we;
  logic [31:0]       dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]        dmem_be;
  logic              dmem_ready, dmem_rvalid;
  logic [4:0]        wb_destReg;
  logic [3:0][7:0]   wb_data_from_mem;
  logic              wb_regWrite, wb_memtoreg, misalign_err;
  logic [31:0]       wb_alu_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .ex_destReg(ex_destReg), .ex_regWrite(ex_regWrite), .ex_memtoreg(ex_memtoreg),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_destReg(wb_destReg), .wb_data_from_mem(wb_data_from_mem), .wb_regWrite(wb_regWrite),
    .wb_memtoreg(wb_memtoreg), .wb_alu_out(wb_alu_out), .misalign_err(misalign_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int size_bytes(input int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit model_legal(input bit is_load, input int f3, input int addr);
    if (is_load) begin
      if (!(f3 inside {0, 1, 2, 4, 5})) return 1'b0;
    end else if (!(f3 inside {0, 1, 2})) return 1'b0;
    return (addr & (size_bytes(f3) - 1)) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input int addr, input int f3);
    int     nbits;
    longint v;
    nbits = 8 * size_bytes(f3);
    v = longint'({32'd0, rdata} >> (8 * (addr & 3)));
    if (nbits < 32) v = v % (longint'(1) << nbits);
    if (f3 < 4 && nbits < 32 && v >= (longint'(1) << (nbits - 1))) v = v - (longint'(1) << nbits);
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_be(input int f3, input int addr);
    if (size_bytes(f3) == 4) return 32'hF;
    return 32'(((1 << size_bytes(f3)) - 1) << (addr & 3));
  endfunction

  function automatic logic [31:0] model_wdata(input int f3, input logic [31:0] d);
    if (size_bytes(f3) == 1) return 32'(d % 256) * 32'h0101_0101;
    if (size_bytes(f3) == 2) return 32'(d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // kind: 0 = ALU op, 1 = load, 2 = store. Entered and left at posedge+1.
  task automatic run_op(input bit valid, input int kind, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] sdata, input logic [4:0] rd,
                        input bit rw, input bit m2r, input logic [31:0] rdata,
                        input int rdy_dly, input int rv_dly);
    bit is_mem, legal, last;
    ex_valid = valid; ex_alu_out = addr; ex_store_data = sdata; ex_funct3 = f3;
    ex_mem_read = (kind == 1); ex_mem_write = (kind == 2);
    ex_destReg = rd; ex_regWrite = rw; ex_memtoreg = m2r;
    is_mem = valid && kind != 0;
    legal  = is_mem && model_legal(kind == 1, int'(f3), int'(addr));

    if (!legal) begin
      dmem_ready = 1'($urandom_range(0, 1)); dmem_rvalid = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      #4;
      check("no_req", 32'(dmem_req), 32'd0);
      check("no_stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      check("wb_regWrite", 32'(wb_regWrite), 32'(valid && !is_mem && rw));
      check("misalign_err", 32'(misalign_err), 32'(is_mem));
      if (valid && !is_mem) begin
        check("wb_alu_out", wb_alu_out, addr);
        check("wb_destReg", 32'(wb_destReg), 32'(rd));
        check("wb_data_alu", wb_data_from_mem, 32'd0);
      end
    end else begin
      for (int c = 0; c <= rdy_dly; c++) begin
        dmem_ready = (c == rdy_dly); dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #4;
        check("req", 32'(dmem_req), 32'd1);
        check("we", 32'(dmem_we), 32'(kind == 2));
        check("addr", dmem_addr, addr & 32'hFFFF_FFFC);
        check("stall_req", 32'(mem_stall), 32'(kind == 1 || c != rdy_dly));
        if (kind == 2) begin
          check("be", 32'(dmem_be), model_be(int'(f3), int'(addr)));
          check("wdata", dmem_wdata, model_wdata(int'(f3), sdata));
        end
        @(posedge clk); #1;
        last = (kind == 2) && (c == rdy_dly);
        check("wb_regWrite_req", 32'(wb_regWrite), 32'(last && rw));
        check("misalign_ok", 32'(misalign_err), 32'd0);
        if (last) begin
          check("st_alu_out", wb_alu_out, addr);
          check("st_destReg", 32'(wb_destReg), 32'(rd));
          check("st_memtoreg", 32'(wb_memtoreg), 32'(m2r));
        end
      end
      if (kind == 1) begin
        for (int c = 1; c <= rv_dly; c++) begin
          dmem_ready = 1'($urandom_range(0, 1)); dmem_rvalid = (c == rv_dly);
          dmem_rdata = (c == rv_dly) ? rdata : $urandom;
          #4;
          check("req_wait", 32'(dmem_req), 32'd0);
          check("stall_wait", 32'(mem_stall), 32'(c != rv_dly));
          @(posedge clk); #1;
          check("wb_regWrite_wait", 32'(wb_regWrite), 32'((c == rv_dly) && rw));
          if (c == rv_dly) begin
            check("ld_data", wb_data_from_mem, model_load(rdata, int'(addr), int'(f3)));
            check("ld_destReg", 32'(wb_destReg), 32'(rd));
            check("ld_memtoreg", 32'(wb_memtoreg), 32'(m2r));
            check("ld_alu_out", wb_alu_out, addr);
          end
        end
      end
    end
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
  endtask

  initial begin
    int          kind, f3;
    logic [31:0] addr;
    rst = 1'b1;
    ex_valid = 1'b0; ex_alu_out = '0; ex_store_data = '0; ex_mem_read = 1'b0;
    ex_mem_write = 1'b0; ex_funct3 = '0; ex_destReg = '0; ex_regWrite = 1'b0;
    ex_memtoreg = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    #2;
    check("rst_regWrite", 32'(wb_regWrite), 32'd0);
    check("rst_alu_out", wb_alu_out, 32'd0);
    check("rst_data", wb_data_from_mem, 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    run_op(1, 0, 32'h1234, 3'b000, 0, 5'd5, 1, 0, 0, 0, 0);
    // rvalid one cycle after entering WAIT_RESP: two stalled cycles.
    run_op(1, 1, 32'h103, 3'b000, 0, 5'd7, 1, 1, 32'h80FF_0000, 0, 2);
    run_op(1, 2, 32'h22, 3'b001, 32'hABCD, 5'd0, 0, 0, 0, 3, 0);
    run_op(1, 1, 32'h101, 3'b010, 0, 5'd9, 1, 1, 0, 0, 1);
    run_op(1, 1, 32'h2, 3'b101, 0, 5'd3, 1, 1, 32'h8001_0000, 0, 1);
    run_op(1, 2, 32'h41, 3'b100, 32'h55, 5'd0, 0, 0, 0, 0, 0);

    // Reset while a load waits for its response; the late rvalid must be dropped.
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_alu_out = 32'h40;
    ex_regWrite = 1'b1; ex_memtoreg = 1'b1; ex_destReg = 5'd12; dmem_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    #2; rst = 1'b1; ex_valid = 1'b0; ex_mem_read = 1'b0; #1;
    check("rstmid_regWrite", 32'(wb_regWrite), 32'd0);
    check("rstmid_req", 32'(dmem_req), 32'd0);
    check("rstmid_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("late_rv_regWrite", 32'(wb_regWrite), 32'd0);
    check("late_rv_data", wb_data_from_mem, 32'd0);
    dmem_rvalid = 1'b0;

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      f3   = $urandom_range(0, 7);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & 32'hFFFF_FFF0 | 32'(size_bytes(f3) * $urandom_range(0, 1));
      run_op($urandom_range(0, 7) != 0, kind, addr, 3'(f3), $urandom, 5'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(0, 3), $urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
